// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared types and constants for the keyboard reaction game:
//               state encoding, settings-field selector, display glyph
//               words, fixed LED patterns, LFSR seed and BCD helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SET  = 2'd1,
        ST_PLAY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        FLD_TIME = 1'b0,
        FLD_GOAL = 1'b1
    } field_t;

    localparam logic [3:0]  BLANK         = 4'hF;
    localparam logic [15:0] BLANK_WORD    = {4{BLANK}};
    localparam logic [15:0] WIN_WORD      = 16'hFABC;
    localparam logic [15:0] LOSE_WORD     = 16'hD05E;

    localparam logic [15:0] LED_IDLE      = 16'h8001;
    localparam logic [15:0] LED_SET_TIME  = 16'hFF01;
    localparam logic [15:0] LED_SET_GOAL  = 16'h80FF;
    localparam logic [6:0]  LED_PLAY_TAIL = 7'b0000011;

    localparam logic [8:0]  LFSR_SEED     = 9'h160;

    // Two BCD digits to binary (0..99).
    function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
        return ({3'b000, b[7:4]} * 7'd10) + {3'b000, b[3:0]};
    endfunction

    // Binary 0..99 to two BCD digits {tens, ones}.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] x);
        return (8'(x / 7'd10) << 4) | 8'(x % 7'd10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/target_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : target_lfsr
// Description : 9-bit LFSR that chooses which mole targets are lit.
//               Ports: clk, rst (async, active-high), load (reload seed),
//               step (advance one position), q[8:0] (current pattern).
// Revision    : 1.0 - initial release
// ============================================================================
module target_lfsr
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    output logic [8:0] q
);

    logic [8:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (load) begin
            r_lfsr <= LFSR_SEED;
        end else if (step) begin
            // Bit 0 feeds back into the top and into taps 6, 5 and 3.
            r_lfsr <= {r_lfsr[0], r_lfsr[8], r_lfsr[7] ^ r_lfsr[0],
                       r_lfsr[6] ^ r_lfsr[0], r_lfsr[5], r_lfsr[4] ^ r_lfsr[0],
                       r_lfsr[3], r_lfsr[2], r_lfsr[1]};
        end
    end

    assign q = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/mole_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mole_game_ctrl
// Description : Sequencer for the keyboard reaction game. IDLE -> SET ->
//               PLAY -> DONE, paced by an internal one-second tick enable.
//               Inputs : clk, rst (async, active-high), start pulse,
//                        key_valid / key_digit[3:0] / key_space key events.
//               Outputs: led[15:0] LED bank, nums[15:0] display nibbles,
//                        state[1:0], win (result of the last game).
//               All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module mole_game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 100_000_000,
    parameter int unsigned FINAL_SECS  = 4,
    parameter logic [7:0]  DEF_TIME    = 8'h30,
    parameter logic [7:0]  DEF_GOAL    = 8'h10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        key_space,
    output logic [15:0] led,
    output logic [15:0] nums,
    output logic [1:0]  state,
    output logic        win
);

    localparam int unsigned     c_TICK_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_CYCLES - 1);
    localparam int unsigned     c_DONE_W    = (FINAL_SECS > 1) ? $clog2(FINAL_SECS) : 1;
    localparam logic [c_DONE_W-1:0] c_DONE_LAST = c_DONE_W'(FINAL_SECS - 1);

    state_t                r_state;
    field_t                r_field;
    logic [c_TICK_W-1:0]   r_tick_cnt;
    logic [c_DONE_W-1:0]   r_done_cnt;
    logic [7:0]            r_time_bcd;
    logic [7:0]            r_goal_bcd;
    logic [6:0]            r_remaining;
    logic [6:0]            r_goal_bin;
    logic [6:0]            r_hits;
    logic [8:0]            r_hit_mask;
    logic [15:0]           r_led;
    logic [15:0]           r_nums;
    logic                  r_win;

    logic                  w_tick;
    logic [8:0]            w_lfsr;
    logic [8:0]            w_targets;
    logic                  w_key_is_digit;
    logic [3:0]            w_hit_idx;
    logic [8:0]            w_hit_onehot;
    logic                  w_hit;
    logic                  w_can_start;
    logic                  w_play_exit;
    logic                  w_lfsr_load;
    logic                  w_lfsr_step;

    assign w_tick         = (r_tick_cnt == c_TICK_LAST);
    assign w_targets      = w_lfsr & r_hit_mask;
    assign w_key_is_digit = (key_digit <= 4'd9);

    // Digit d addresses led[16-d], which is target bit 9-d.
    assign w_hit_idx      = 4'd9 - key_digit;
    assign w_hit_onehot   = (key_valid && (key_digit != 4'd0) && w_key_is_digit)
                            ? (9'd1 << w_hit_idx) : 9'd0;
    assign w_hit          = |(w_hit_onehot & w_targets);

    assign w_can_start    = (r_time_bcd != 8'h00) && (r_goal_bcd != 8'h00);
    assign w_play_exit    = (r_hits == r_goal_bin) || (r_remaining == 7'd0);
    assign w_lfsr_load    = (r_state == ST_SET) && start && w_can_start;
    assign w_lfsr_step    = (r_state == ST_PLAY) && !w_play_exit && w_tick;

    target_lfsr u_target_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (w_lfsr_load),
        .step (w_lfsr_step),
        .q    (w_lfsr)
    );

    // Outputs are computed from the registers held during this cycle, so
    // led/nums always trail the state/register they describe by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_field     <= FLD_TIME;
            r_tick_cnt  <= '0;
            r_done_cnt  <= '0;
            r_time_bcd  <= DEF_TIME;
            r_goal_bcd  <= DEF_GOAL;
            r_remaining <= 7'd0;
            r_goal_bin  <= 7'd0;
            r_hits      <= 7'd0;
            r_hit_mask  <= '1;
            r_led       <= LED_IDLE;
            r_nums      <= BLANK_WORD;
            r_win       <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    r_led      <= LED_IDLE;
                    r_nums     <= BLANK_WORD;
                    r_time_bcd <= DEF_TIME;
                    r_goal_bcd <= DEF_GOAL;
                    r_field    <= FLD_TIME;
                    if (start) begin
                        r_state    <= ST_SET;
                        r_tick_cnt <= '0;
                    end
                end

                ST_SET: begin
                    r_led  <= (r_field == FLD_GOAL) ? LED_SET_GOAL : LED_SET_TIME;
                    r_nums <= {r_time_bcd, r_goal_bcd};
                    if (start && w_can_start) begin
                        r_state     <= ST_PLAY;
                        r_tick_cnt  <= '0;
                        r_remaining <= bcd_to_bin(r_time_bcd);
                        r_goal_bin  <= bcd_to_bin(r_goal_bcd);
                        r_hits      <= 7'd0;
                        r_hit_mask  <= '1;
                    end else begin
                        if (key_valid && w_key_is_digit) begin
                            if (r_field == FLD_GOAL) begin
                                r_goal_bcd <= {r_goal_bcd[3:0], key_digit};
                            end else begin
                                r_time_bcd <= {r_time_bcd[3:0], key_digit};
                            end
                        end
                        if (key_space) begin
                            r_field <= (r_field == FLD_TIME) ? FLD_GOAL : FLD_TIME;
                        end
                    end
                end

                ST_PLAY: begin
                    r_led  <= {w_targets, LED_PLAY_TAIL};
                    r_nums <= {bin_to_bcd(r_remaining), bin_to_bcd(r_hits)};
                    if (r_hits == r_goal_bin) begin
                        r_state    <= ST_DONE;
                        r_win      <= 1'b1;
                        r_tick_cnt <= '0;
                        r_done_cnt <= '0;
                    end else if (r_remaining == 7'd0) begin
                        r_state    <= ST_DONE;
                        r_win      <= 1'b0;
                        r_tick_cnt <= '0;
                        r_done_cnt <= '0;
                    end else begin
                        if (w_hit) begin
                            r_hits <= r_hits + 7'd1;
                        end
                        // remaining is non-zero here, so the decrement cannot
                        // wrap; a tick's mask reset overrides a same-cycle hit.
                        if (w_tick) begin
                            r_remaining <= r_remaining - 7'd1;
                            r_hit_mask  <= '1;
                        end else if (w_hit) begin
                            r_hit_mask <= r_hit_mask & ~w_hit_onehot;
                        end
                    end
                end

                ST_DONE: begin
                    r_led  <= r_done_cnt[0] ? 16'h0000 : 16'hFFFF;
                    r_nums <= r_win ? WIN_WORD : LOSE_WORD;
                    if (w_tick) begin
                        if (r_done_cnt == c_DONE_LAST) begin
                            r_state    <= ST_IDLE;
                            r_tick_cnt <= '0;
                        end else begin
                            r_done_cnt <= r_done_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign led   = r_led;
    assign nums  = r_nums;
    assign state = r_state;
    assign win   = r_win;

endmodule
`default_nettype wire

// File: tb/tb_mole_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mole_game_ctrl
// Description : Self-checking bench for mole_game_ctrl with a short second
//               (4 clocks) and a 4-second result display. A game-level
//               model is compared against the DUT every cycle; directed
//               checks pin the model with hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mole_game_ctrl;

    localparam int TICK  = 4;
    localparam int FINAL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_digit = 4'h0;
    logic        key_space = 1'b0;
    logic [15:0] led;
    logic [15:0] nums;
    logic [1:0]  state;
    logic        win;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    mole_game_ctrl #(
        .TICK_CYCLES (TICK),
        .FINAL_SECS  (FINAL),
        .DEF_TIME    (8'h30),
        .DEF_GOAL    (8'h10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .key_space (key_space),
        .led       (led),
        .nums      (nums),
        .state     (state),
        .win       (win)
    );

    // ------------------------------------------------------------------
    // Game model: integer seconds/hits, a set of already-scored targets,
    // and a count of elapsed clocks within the current second.
    // ------------------------------------------------------------------
    typedef struct {
        int          st;
        logic [7:0]  tm;
        logic [7:0]  gl;
        bit          sel_goal;
        int          rem;
        int          goal_n;
        int          hits;
        int          tick;
        int          dticks;
        logic [8:0]  lfsr;
        logic [8:0]  scored;
        logic        win;
        logic [15:0] led;
        logic [15:0] nums;
    } model_t;

    model_t M;

    function automatic logic [8:0] lfsr_next(input logic [8:0] l);
        return {l[0], l[8], l[7] ^ l[0], l[6] ^ l[0], l[5], l[4] ^ l[0], l[3], l[2], l[1]};
    endfunction

    function automatic logic [7:0] to_bcd(input int x);
        return {4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m.st = 0; m.tm = 8'h30; m.gl = 8'h10; m.sel_goal = 1'b0;
        m.rem = 0; m.goal_n = 0; m.hits = 0; m.tick = 0; m.dticks = 0;
        m.lfsr = 9'h160; m.scored = '0; m.win = 1'b0;
        m.led = 16'h8001; m.nums = 16'hFFFF;
        return m;
    endfunction

    function automatic model_t model_next(input model_t c, input logic st, input logic kv,
                                          input logic [3:0] kd, input logic ks);
        model_t     n  = c;
        logic [8:0] tg = c.lfsr & ~c.scored;
        bit         tk = (c.tick == TICK - 1);
        int         d  = int'(kd);
        // Displayed values describe the state held during this cycle.
        case (c.st)
            0: begin n.led = 16'h8001; n.nums = 16'hFFFF; end
            1: begin n.led = c.sel_goal ? 16'h80FF : 16'hFF01; n.nums = {c.tm, c.gl}; end
            2: begin n.led = {tg, 7'b0000011}; n.nums = {to_bcd(c.rem), to_bcd(c.hits)}; end
            default: begin
                n.led  = (c.dticks % 2 == 1) ? 16'h0000 : 16'hFFFF;
                n.nums = c.win ? 16'hFABC : 16'hD05E;
            end
        endcase
        case (c.st)
            0: begin
                n.tm = 8'h30; n.gl = 8'h10; n.sel_goal = 1'b0;
                if (st) n.st = 1;
            end
            1: begin
                if (st && c.tm != 8'h00 && c.gl != 8'h00) begin
                    n.st = 2; n.rem = from_bcd(c.tm); n.goal_n = from_bcd(c.gl);
                    n.hits = 0; n.lfsr = 9'h160; n.scored = '0;
                end else begin
                    if (kv && d <= 9) begin
                        if (c.sel_goal) n.gl = {c.gl[3:0], kd};
                        else            n.tm = {c.tm[3:0], kd};
                    end
                    if (ks) n.sel_goal = !c.sel_goal;
                end
            end
            2: begin
                if (c.hits == c.goal_n) begin
                    n.st = 3; n.win = 1'b1; n.dticks = 0;
                end else if (c.rem == 0) begin
                    n.st = 3; n.win = 1'b0; n.dticks = 0;
                end else begin
                    if (kv && d >= 1 && d <= 9 && tg[9 - d]) begin
                        n.hits = c.hits + 1;
                        n.scored[9 - d] = 1'b1;
                    end
                    if (tk) begin
                        n.rem = c.rem - 1; n.lfsr = lfsr_next(c.lfsr); n.scored = '0;
                    end
                end
            end
            default: begin
                if (tk) begin
                    n.dticks = c.dticks + 1;
                    if (n.dticks == FINAL) n.st = 0;
                end
            end
        endcase
        n.tick = (n.st != c.st || tk) ? 0 : c.tick + 1;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) M <= model_reset();
        else     M <= model_next(M, start, key_valid, key_digit, key_space);
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            checks++;
            if (led !== M.led || nums !== M.nums || state !== 2'(M.st) || win !== M.win) begin
                failures++;
                $display("FAIL model t=%0t led=%h/%h nums=%h/%h state=%0d/%0d win=%0b/%0b (got/exp)",
                         $time, led, M.led, nums, M.nums, state, M.st, win, M.win);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic press_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic press_space();
        key_space = 1'b1; step(); key_space = 1'b0;
    endtask

    task automatic press_key(input logic [3:0] d);
        key_valid = 1'b1; key_digit = d; step(); key_valid = 1'b0; key_digit = 4'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen_dark;

        #2 rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset / IDLE
        repeat (10) step();
        check("idle_led",   led,           16'h8001);
        check("idle_nums",  nums,          16'hFFFF);
        check("idle_state", {14'd0, state}, 16'd0);

        // Enter SET with defaults
        press_start();
        step();
        check("set_state", {14'd0, state}, 16'd1);
        check("set_nums",  nums,           16'h3010);
        check("set_led",   led,            16'hFF01);

        // Digit entry: time 30 -> 00 -> 05, space, non-digit ignored, goal 10 -> 00 -> 03
        press_key(4'd0);
        press_key(4'd5);
        press_space();
        step();
        check("set_led_goal", led, 16'h80FF);
        press_key(4'hF);
        press_key(4'd0);
        press_key(4'd3);
        step();
        check("set_nums_entry", nums, 16'h0503);

        // Goal 03 -> 30 -> 00, start must be refused
        press_key(4'd0);
        press_key(4'd0);
        press_start();
        step();
        check("zero_goal_stay", {14'd0, state}, 16'd1);
        check("zero_goal_nums", nums,           16'h0500);

        // Goal 01, time 05: win path. Seed 9'h160 lights led[15], not led[14].
        press_key(4'd1);
        press_start();
        press_key(4'd2);                       // miss
        check("play_led_seed", led,            16'hB003);
        check("play_nums0",    nums,           16'h0500);
        check("play_state",    {14'd0, state}, 16'd2);
        press_key(4'd1);                       // hit on led[15]
        step();
        check("win_hits_nums", nums,           16'h0501);
        check("win_state",     {14'd0, state}, 16'd3);
        check("win_flag",      {15'd0, win},   16'd1);
        step();
        check("win_word", nums, 16'hFABC);
        check("win_led0", led,  16'hFFFF);

        // DONE lasts 4 ticks = 16 clocks; one has already elapsed.
        n = 0; seen_dark = 1'b0;
        while (state == 2'd3 && n < 100) begin
            step(); n++;
            if (state == 2'd3 && led == 16'h0000) seen_dark = 1'b1;
        end
        check("done_dwell", 16'(n), 16'd15);
        check("done_blink", {15'd0, seen_dark}, 16'd1);

        // Loss path: time 02, goal 10, no keys. PLAY lasts 2 ticks + 1 exit cycle.
        press_start();
        press_key(4'd0);
        press_key(4'd2);
        press_start();
        n = 0;
        while (state == 2'd2 && n < 50) begin
            step(); n++;
        end
        check("loss_play_len", 16'(n), 16'd9);
        step();
        check("loss_word", nums,         16'hD05E);
        check("loss_flag", {15'd0, win}, 16'd0);
        n = 0;
        while (state != 2'd0 && n < 60) begin
            step(); n++;
        end
        check("loss_back_idle", {14'd0, state}, 16'd0);

        // Target masking: time 09, goal 10, digit 1 twice in one second
        press_start();
        press_key(4'd0);
        press_key(4'd9);
        press_start();
        press_key(4'd1);
        press_key(4'd1);
        check("mask_led", led, 16'h3003);
        step();
        check("mask_hits", nums, 16'h0901);

        // Reset mid-play takes effect without a clock edge
        rst = 1'b1;
        #1;
        check("rst_state", {14'd0, state}, 16'd0);
        check("rst_led",   led,            16'h8001);
        check("rst_nums",  nums,           16'hFFFF);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        press_start();
        step();
        check("rst_defaults", nums, 16'h3010);

        // Long game with a key every cycle: hits, misses, and hit/tick overlap
        press_key(4'd2);
        press_key(4'd0);
        press_space();
        press_key(4'd9);
        press_key(4'd9);
        press_start();
        for (int i = 0; i < 60; i++) press_key(4'(1 + (i % 9)));
        n = 0;
        while (state != 2'd3 && n < 100) begin
            step(); n++;
        end
        check("long_done", {14'd0, state}, 16'd3);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
